// File: rtl/watch_time_set_ctrl.sv
// Watch time-setting controller: debounced buttons with auto-repeat, a four-state
// edit sequencer, shadow time fields, a one-cycle load strobe and a field blink mask.
module watch_time_set_ctrl #(
  parameter int unsigned DEBOUNCE_CYCLES   = 250000,
  parameter int unsigned BLINK_HALF_CYCLES = 12500000,
  parameter int unsigned REPEAT_DELAY      = 25000000,
  parameter int unsigned REPEAT_RATE       = 5000000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       btn_mode,
  input  logic       btn_inc,
  input  logic       btn_dec,
  input  logic [4:0] cur_hour,
  input  logic [5:0] cur_minute,
  input  logic [5:0] cur_second,
  output logic [4:0] set_hour,
  output logic [5:0] set_minute,
  output logic [5:0] set_second,
  output logic       load,
  output logic [1:0] mode,
  output logic [2:0] blink_mask
);

  localparam int unsigned DBW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int unsigned HW  = $clog2(REPEAT_DELAY + 1);
  localparam int unsigned BW  = $clog2(BLINK_HALF_CYCLES + 1);
  localparam logic [DBW-1:0] DB_LAST     = DBW'(DEBOUNCE_CYCLES - 1);
  localparam logic [HW-1:0]  HOLD_FIRE   = HW'(REPEAT_DELAY);
  localparam logic [HW-1:0]  HOLD_RELOAD = HW'(REPEAT_DELAY - REPEAT_RATE + 1);
  localparam logic [BW-1:0]  BLINK_LAST  = BW'(BLINK_HALF_CYCLES - 1);

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    SET_H = 2'd1,
    SET_M = 2'd2,
    SET_S = 2'd3
  } state_t;

  // Button index: 0 = mode, 1 = inc, 2 = dec
  logic [2:0]     raw, sync1, sync2, acc, acc_d, press;
  logic [DBW-1:0] db_cnt [3];
  logic [HW-1:0]  hold_cnt [2];
  logic [1:0]     rep;
  logic           mode_ev, inc_ev, dec_ev, edit, restart;

  state_t         state, state_nx;
  logic [4:0]     hour_nx;
  logic [5:0]     min_nx, sec_nx;
  logic [BW-1:0]  bcnt, bcnt_nx;
  logic           phase, phase_nx, load_nx;
  logic [2:0]     mask_nx;

  assign raw = {btn_dec, btn_inc, btn_mode};

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync1 <= '0;
      sync2 <= '0;
      acc   <= '0;
      acc_d <= '0;
      for (int unsigned i = 0; i < 3; i++) db_cnt[i] <= '0;
    end else begin
      sync1 <= raw;
      sync2 <= sync1;
      acc_d <= acc;
      for (int unsigned i = 0; i < 3; i++) begin
        if (sync2[i] == acc[i]) begin
          db_cnt[i] <= '0;
        end else if (db_cnt[i] == DB_LAST) begin
          db_cnt[i] <= '0;
          acc[i]    <= sync2[i];
        end else begin
          db_cnt[i] <= db_cnt[i] + DBW'(1);
        end
      end
    end
  end

  assign press = acc & ~acc_d;

  // Counter sits at 0 on the press cycle; after the first repeat it reloads so
  // that it reaches HOLD_FIRE again every REPEAT_RATE cycles.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int unsigned i = 0; i < 2; i++) hold_cnt[i] <= '0;
    end else begin
      for (int unsigned i = 0; i < 2; i++) begin
        if (!acc[i+1])                     hold_cnt[i] <= '0;
        else if (hold_cnt[i] == HOLD_FIRE) hold_cnt[i] <= HOLD_RELOAD;
        else                               hold_cnt[i] <= hold_cnt[i] + HW'(1);
      end
    end
  end

  assign rep[0]  = acc[1] & (hold_cnt[0] == HOLD_FIRE);
  assign rep[1]  = acc[2] & (hold_cnt[1] == HOLD_FIRE);
  assign mode_ev = press[0];
  assign inc_ev  = press[1] | rep[0];
  assign dec_ev  = press[2] | rep[1];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= RUN;
    else      state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    if (mode_ev) begin
      unique case (state)
        RUN:   state_nx = SET_H;
        SET_H: state_nx = SET_M;
        SET_M: state_nx = SET_S;
        SET_S: state_nx = RUN;
        default: state_nx = RUN;
      endcase
    end
  end

  assign edit    = !mode_ev && (state != RUN) && (inc_ev ^ dec_ev);
  assign restart = (state_nx != state) || edit;

  always_comb begin
    hour_nx = set_hour;
    min_nx  = set_minute;
    sec_nx  = set_second;
    if (mode_ev && state == RUN) begin
      hour_nx = cur_hour;
      min_nx  = cur_minute;
      sec_nx  = cur_second;
    end else if (edit) begin
      unique case (state)
        SET_H: if (inc_ev) hour_nx = (set_hour == 5'd23) ? 5'd0 : set_hour + 5'd1;
               else        hour_nx = (set_hour == 5'd0) ? 5'd23 : set_hour - 5'd1;
        SET_M: if (inc_ev) min_nx = (set_minute == 6'd59) ? 6'd0 : set_minute + 6'd1;
               else        min_nx = (set_minute == 6'd0) ? 6'd59 : set_minute - 6'd1;
        SET_S: if (inc_ev) sec_nx = (set_second == 6'd59) ? 6'd0 : set_second + 6'd1;
               else        sec_nx = (set_second == 6'd0) ? 6'd59 : set_second - 6'd1;
        default: ;
      endcase
    end
  end

  always_comb begin
    bcnt_nx  = bcnt + BW'(1);
    phase_nx = phase;
    if (restart) begin
      bcnt_nx  = '0;
      phase_nx = 1'b0;
    end else if (bcnt == BLINK_LAST) begin
      bcnt_nx  = '0;
      phase_nx = ~phase;
    end
    unique case (state_nx)
      SET_H:   mask_nx = {phase_nx, 2'b00};
      SET_M:   mask_nx = {1'b0, phase_nx, 1'b0};
      SET_S:   mask_nx = {2'b00, phase_nx};
      default: mask_nx = '0;
    endcase
    load_nx = mode_ev && (state == SET_S);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      set_hour   <= '0;
      set_minute <= '0;
      set_second <= '0;
      load       <= 1'b0;
      bcnt       <= '0;
      phase      <= 1'b0;
      blink_mask <= '0;
    end else begin
      set_hour   <= hour_nx;
      set_minute <= min_nx;
      set_second <= sec_nx;
      load       <= load_nx;
      bcnt       <= bcnt_nx;
      phase      <= phase_nx;
      blink_mask <= mask_nx;
    end
  end

  assign mode = state;

endmodule

// File: tb/tb_watch_time_set_ctrl.sv
// Bench for watch_time_set_ctrl: press-level reference model feeding a scoreboard
// of expected output changes, plus a continuous blink-mask monitor.
module tb_watch_time_set_ctrl;
  localparam int DB = 4, BH = 8, RD = 16, RR = 4;

  logic       clk = 1'b0, rst = 1'b1;
  logic       btn_mode = 1'b0, btn_inc = 1'b0, btn_dec = 1'b0;
  logic [4:0] cur_hour = '0;
  logic [5:0] cur_minute = '0, cur_second = '0;
  logic [4:0] set_hour;
  logic [5:0] set_minute, set_second;
  logic       load;
  logic [1:0] mode;
  logic [2:0] blink_mask;

  watch_time_set_ctrl #(
    .DEBOUNCE_CYCLES(DB), .BLINK_HALF_CYCLES(BH),
    .REPEAT_DELAY(RD), .REPEAT_RATE(RR)
  ) dut (
    .clk(clk), .rst(rst), .btn_mode(btn_mode), .btn_inc(btn_inc), .btn_dec(btn_dec),
    .cur_hour(cur_hour), .cur_minute(cur_minute), .cur_second(cur_second),
    .set_hour(set_hour), .set_minute(set_minute), .set_second(set_second),
    .load(load), .mode(mode), .blink_mask(blink_mask)
  );

  typedef struct {
    int t;  // expected cycle of appearance, -1 = any
    int md;
    int h;
    int mi;
    int s;
    int ld;
  } rec_t;

  rec_t q[$];
  int cyc = 0, n_chk = 0, n_fail = 0;
  int m = 0, mh = 0, mm = 0, ms = 0;  // reference: mode and shadow fields

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic void push(input int t, input int ld);
    q.push_back('{t, m, mh, mm, ms, ld});
  endfunction

  // A button held from cycle k is accepted at k+6; inc/dec then repeat RD
  // cycles later and every RR cycles after that.
  function automatic bit fires(input int n, input bit repeats);
    return (n == 0) || (repeats && n >= RD && (n - RD) % RR == 0);
  endfunction

  function automatic void model_step(input bit em, input bit ei, input bit ed, input int t);
    int d;
    if (em) begin
      if (m == 0) begin
        mh = int'(cur_hour); mm = int'(cur_minute); ms = int'(cur_second);
      end
      m = (m + 1) % 4;
      if (m == 0) begin
        push(t, 1);
        push(t + 1, 0);
      end else begin
        push(t, 0);
      end
    end else if (m != 0 && ei != ed) begin
      d = ei ? 1 : -1;
      case (m)
        1: mh = (mh + d + 24) % 24;
        2: mm = (mm + d + 60) % 60;
        default: ms = (ms + d + 60) % 60;
      endcase
      push(t, 0);
    end
  endfunction

  task automatic press(input bit pm, input bit pi, input bit pd, input int hold);
    int k, r;
    @(negedge clk);
    k = cyc;
    r = k + hold;
    btn_mode = pm; btn_inc = pi; btn_dec = pd;
    for (int p = k + 6; p < r + 6; p++)
      model_step(pm && fires(p - k - 6, 1'b0), pi && fires(p - k - 6, 1'b1),
                 pd && fires(p - k - 6, 1'b1), p + 1);
    repeat (hold) @(negedge clk);
    btn_mode = 1'b0; btn_inc = 1'b0; btn_dec = 1'b0;
    repeat (12) @(negedge clk);
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic bounce_mode();
    @(negedge clk);
    btn_mode = 1'b1; idle(2);
    btn_mode = 1'b0; idle(2);
    btn_mode = 1'b1; idle(2);
    btn_mode = 1'b0; idle(12);
  endtask

  // Monitor: every change of {mode, set_*, load} must match the next queued record.
  logic [19:0] now_t, prev_t = '0;
  rec_t        rp;
  int          exp_mode = 0, rc = 0;
  logic [2:0]  exp_mask;

  always @(negedge clk) begin
    now_t = {mode, set_hour, set_minute, set_second, load};
    if (now_t != prev_t) begin
      n_chk++;
      if (q.size() == 0) begin
        n_fail++;
        $display("FAIL unexpected_change: cycle %0d mode=%0d set=%0d:%0d:%0d load=%0d, required no change",
                 cyc, mode, set_hour, set_minute, set_second, load);
        exp_mode = int'(mode);
      end else begin
        rp = q.pop_front();
        if (int'(mode) != rp.md || int'(set_hour) != rp.h || int'(set_minute) != rp.mi ||
            int'(set_second) != rp.s || int'(load) != rp.ld || (rp.t >= 0 && cyc != rp.t)) begin
          n_fail++;
          $display("FAIL output_change: cycle %0d mode=%0d set=%0d:%0d:%0d load=%0d, required cycle %0d mode=%0d set=%0d:%0d:%0d load=%0d",
                   cyc, mode, set_hour, set_minute, set_second, load,
                   rp.t, rp.md, rp.h, rp.mi, rp.s, rp.ld);
        end
        exp_mode = rp.md;
      end
      rc = cyc;
      prev_t = now_t;
    end
    if (exp_mode == 0 || ((cyc - rc) / BH) % 2 == 0) exp_mask = 3'b000;
    else exp_mask = 3'(3'b100 >> (exp_mode - 1));
    n_chk++;
    if (blink_mask !== exp_mask) begin
      n_fail++;
      $display("FAIL blink_mask: cycle %0d got %b, expected %b", cyc, blink_mask, exp_mask);
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not complete, %0d cycles elapsed", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int op, h;
    #1 rst = 1'b0;
    idle(4);
    @(negedge clk); #2 rst = 1'b1;
    idle(4);
    chk("reset_mode", int'(mode), 0);
    chk("reset_load", int'(load), 0);
    chk("reset_mask", int'(blink_mask), 0);
    chk("reset_hour", int'(set_hour), 0);
    chk("reset_min_sec", int'({set_minute, set_second}), 0);

    // Enter SET_H capturing 13:45:30, then watch the blink for a while
    cur_hour = 5'd13; cur_minute = 6'd45; cur_second = 6'd30;
    press(1, 0, 0, 10);
    idle(30);
    chk("capture_mode", int'(mode), 1);
    chk("capture_time", int'({set_hour, set_minute, set_second}), int'({5'd13, 6'd45, 6'd30}));

    // Full walk with edits, including a bounced mode button in SET_S
    press(0, 1, 0, 6);
    press(1, 0, 0, 6);
    press(0, 0, 1, 6);
    press(1, 0, 0, 6);
    press(0, 1, 0, 6);
    press(0, 1, 0, 6);
    bounce_mode();
    chk("bounce_mode", int'(mode), 3);
    press(1, 0, 0, 6);
    chk("walk_time", int'({set_hour, set_minute, set_second}), int'({5'd14, 6'd44, 6'd32}));
    press(0, 1, 0, 6);
    chk("run_inc_ignored", int'(set_hour), 14);

    // Wrap boundaries and auto-repeat
    cur_hour = 5'd23; cur_minute = 6'd0; cur_second = 6'd10;
    press(1, 0, 0, 6);
    press(0, 1, 1, 8);
    chk("inc_dec_same_cycle", int'(set_hour), 23);
    press(0, 1, 0, 6);
    chk("hour_wrap_up", int'(set_hour), 0);
    press(1, 0, 0, 6);
    press(0, 0, 1, 6);
    chk("minute_wrap_down", int'(set_minute), 59);
    press(1, 0, 0, 6);
    press(0, 1, 0, 38);
    chk("auto_repeat", int'(set_second), 17);
    press(1, 0, 0, 40);
    chk("held_mode_once", int'(mode), 0);
    chk("load_values", int'({set_hour, set_minute, set_second}), int'({5'd0, 6'd59, 6'd17}));

    // Randomised button activity
    for (int i = 0; i < 30; i++) begin
      if (m == 0) begin
        cur_hour = 5'($urandom_range(0, 23));
        cur_minute = 6'($urandom_range(0, 59));
        cur_second = 6'($urandom_range(0, 59));
      end
      op = int'($urandom_range(0, 4));
      h = int'($urandom_range(6, 50));
      case (op)
        0: press(1, 0, 0, h);
        1: press(0, 1, 0, h);
        2: press(0, 0, 1, h);
        3: press(0, 1, 1, h);
        default: press(1, 1, 0, h);
      endcase
    end

    // Reset in the middle of an edit
    for (int i = 0; i < 4 && m != 2; i++) press(1, 0, 0, 6);
    press(0, 1, 0, 6);
    @(negedge clk);
    m = 0; mh = 0; mm = 0; ms = 0;
    push(-1, 0);
    #2 rst = 1'b0;
    #1;
    chk("async_reset_mode", int'(mode), 0);
    chk("async_reset_mask", int'(blink_mask), 0);
    idle(3);
    @(negedge clk); #2 rst = 1'b1;
    idle(3);
    cur_hour = 5'd7; cur_minute = 6'd8; cur_second = 6'd9;
    press(1, 0, 0, 6);
    press(0, 1, 1, 8);
    chk("post_reset_inc_dec", int'(set_hour), 7);

    idle(20);
    chk("scoreboard_drained", q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
